// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: excepttype codes, CP0
// register addresses, flag bit positions, FSM states and the forwarding helper.
package exc_ctrl_pkg;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

    localparam logic [31:0] EXC_CODE_NONE  = 32'h0000_0000;
    localparam logic [31:0] EXC_CODE_INT   = 32'h0000_0001;
    localparam logic [31:0] EXC_CODE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] EXC_CODE_ADES  = 32'h0000_0005;
    localparam logic [31:0] EXC_CODE_SYS   = 32'h0000_0008;
    localparam logic [31:0] EXC_CODE_BRK   = 32'h0000_0009;
    localparam logic [31:0] EXC_CODE_RI    = 32'h0000_000A;
    localparam logic [31:0] EXC_CODE_OV    = 32'h0000_000C;
    localparam logic [31:0] EXC_CODE_TRAP  = 32'h0000_000D;
    localparam logic [31:0] EXC_CODE_ERET  = 32'h0000_000E;

    localparam logic [4:0]  CP0_REG_STATUS = 5'd12;
    localparam logic [4:0]  CP0_REG_CAUSE  = 5'd13;
    localparam logic [4:0]  CP0_REG_EPC    = 5'd14;

    // Bit positions inside exc_flags_i
    localparam int FLAG_RI     = 0;
    localparam int FLAG_OV     = 1;
    localparam int FLAG_TRAP   = 2;
    localparam int FLAG_SYS    = 3;
    localparam int FLAG_BRK    = 4;
    localparam int FLAG_ADEL_D = 5;
    localparam int FLAG_ADES   = 6;
    localparam int FLAG_ERET   = 7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_e;

    // Returns the WB write data when it targets reg_addr, else the CP0 value.
    function automatic logic [31:0] cp0_fwd(
        input logic        we,
        input logic [4:0]  waddr,
        input logic [4:0]  reg_addr,
        input logic [31:0] wdata,
        input logic [31:0] cur
    );
        logic [31:0] res;
        if (we && (waddr == reg_addr)) begin
            res = wdata;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 bundle seen by the exception sequencer; master is the
// pipeline side, slave is exc_ctrl.
interface exc_ctrl_if;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [5:0]  int_sync_o;
    logic        mem_valid_i;
    logic        mem_stall_i;
    logic [7:0]  exc_flags_i;
    logic        adel_f_i;
    logic [31:0] pc_i;
    logic [31:0] data_addr_i;
    logic        in_delayslot_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic [31:0] excepttype_o;
    logic [31:0] exc_pc_o;
    logic        exc_delayslot_o;
    logic [31:0] bad_addr_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    modport master (
        output int_i, timer_int_i, mem_valid_i, mem_stall_i, exc_flags_i,
               adel_f_i, pc_i, data_addr_i, in_delayslot_i, cp0_status_i,
               cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        input  int_sync_o, excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );

    modport slave (
        input  int_i, timer_int_i, mem_valid_i, mem_stall_i, exc_flags_i,
               adel_f_i, pc_i, data_addr_i, in_delayslot_i, cp0_status_i,
               cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i,
        output int_sync_o, excepttype_o, exc_pc_o, exc_delayslot_o, bad_addr_o,
               flush_o, new_pc_o
    );
endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchroniser for the six asynchronous hardware interrupt lines.
module exc_ctrl_int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] async_int,
    output logic [5:0] sync_int
);
    logic [5:0] sync_r [SYNC_STAGES];

    // Shift the raw lines through SYNC_STAGES flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= 6'd0;
            end
        end else begin
            sync_r[0] <= async_int;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign sync_int = sync_r[SYNC_STAGES-1];
endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer at MEM: prioritises exception flags and
// interrupts into one CP0 excepttype and drives the flush/redirect sequence.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          SYNC_STAGES  = 2
) (
    input logic         clk,
    input logic         rst,
    exc_ctrl_if.slave   bus
);
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    exc_state_e        state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              flush_r;
    logic [31:0]       new_pc_r;
    logic [5:0]        sync_int_s;
    logic [31:0]       st_s, ca_s, epc_s;
    logic              cause_wr_s, int_pend_s, commit_s;
    logic [31:0]       code_s, bad_s;
    logic              unused_bits_s;

    exc_ctrl_int_sync #(.SYNC_STAGES(SYNC_STAGES)) u_int_sync (
        .clk       (clk),
        .rst       (rst),
        .async_int (bus.int_i),
        .sync_int  (sync_int_s)
    );

    assign bus.int_sync_o = sync_int_s | {bus.timer_int_i, 5'b00000};

    // Only IP1..IP0 of CAUSE are software-writable, so only they are forwarded
    assign st_s       = cp0_fwd(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, CP0_REG_STATUS,
                                bus.wb_cp0_wdata_i, bus.cp0_status_i);
    assign epc_s      = cp0_fwd(bus.wb_cp0_we_i, bus.wb_cp0_waddr_i, CP0_REG_EPC,
                                bus.wb_cp0_wdata_i, bus.cp0_epc_i);
    assign cause_wr_s = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == CP0_REG_CAUSE);
    assign ca_s       = {bus.cp0_cause_i[31:10],
                         cause_wr_s ? bus.wb_cp0_wdata_i[9:8] : bus.cp0_cause_i[9:8],
                         bus.cp0_cause_i[7:0]};

    assign int_pend_s = st_s[0] & ~st_s[1] & (|(ca_s[15:8] & st_s[15:8]));
    assign commit_s   = (state_r == ST_IDLE) & bus.mem_valid_i & ~bus.mem_stall_i;
    assign unused_bits_s = ^{st_s[31:16], st_s[7:2], ca_s[31:16], ca_s[7:0]};

    // Priority encoder: first match wins; BadVAddr follows the chosen cause
    always_comb begin
        code_s = EXC_CODE_NONE;
        bad_s  = 32'h0000_0000;
        if (!commit_s) begin
            code_s = EXC_CODE_NONE;
        end else if (int_pend_s) begin
            code_s = EXC_CODE_INT;
        end else if (bus.adel_f_i) begin
            code_s = EXC_CODE_ADEL;
            bad_s  = bus.pc_i;
        end else if (bus.exc_flags_i[FLAG_RI]) begin
            code_s = EXC_CODE_RI;
        end else if (bus.exc_flags_i[FLAG_OV]) begin
            code_s = EXC_CODE_OV;
        end else if (bus.exc_flags_i[FLAG_TRAP]) begin
            code_s = EXC_CODE_TRAP;
        end else if (bus.exc_flags_i[FLAG_SYS]) begin
            code_s = EXC_CODE_SYS;
        end else if (bus.exc_flags_i[FLAG_BRK]) begin
            code_s = EXC_CODE_BRK;
        end else if (bus.exc_flags_i[FLAG_ADEL_D]) begin
            code_s = EXC_CODE_ADEL;
            bad_s  = bus.data_addr_i;
        end else if (bus.exc_flags_i[FLAG_ADES]) begin
            code_s = EXC_CODE_ADES;
            bad_s  = bus.data_addr_i;
        end else if (bus.exc_flags_i[FLAG_ERET]) begin
            code_s = EXC_CODE_ERET;
        end else begin
            code_s = EXC_CODE_NONE;
        end
    end

    // FSM next state: any issued code starts a flush of FLUSH_CYCLES cycles
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (code_s != EXC_CODE_NONE) begin
                    state_nxt_s = ST_FLUSH;
                    cnt_nxt_s   = CNT_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered flush/redirect outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            flush_r  <= 1'b0;
            new_pc_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            flush_r <= (state_nxt_s == ST_FLUSH);
            if (code_s == EXC_CODE_ERET) begin
                new_pc_r <= epc_s;
            end else if (code_s != EXC_CODE_NONE) begin
                new_pc_r <= EXC_VECTOR;
            end else begin
                new_pc_r <= new_pc_r;
            end
        end
    end

    assign bus.excepttype_o    = code_s;
    assign bus.bad_addr_o      = bad_s;
    assign bus.exc_pc_o        = bus.pc_i;
    assign bus.exc_delayslot_o = bus.in_delayslot_i;
    assign bus.flush_o         = flush_r;
    assign bus.new_pc_o        = new_pc_r;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: vector table for the priority encoder plus
// hand sequences for sync latency, forwarding, stall, back-to-back and reset.
module tb_exc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst3 = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exc_ctrl_if bus ();
    exc_ctrl_if bus3 ();

    exc_ctrl #(.FLUSH_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    exc_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  flags;
        logic        adel_f;
        logic        valid;
        logic        stall;
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] epc;
        logic [31:0] pc;
        logic [31:0] daddr;
        logic [31:0] exp_code;
        logic [31:0] exp_bad;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        bus.int_i = 6'd0; bus.timer_int_i = 1'b0; bus.mem_valid_i = 1'b0;
        bus.mem_stall_i = 1'b0; bus.exc_flags_i = 8'd0; bus.adel_f_i = 1'b0;
        bus.pc_i = 32'd0; bus.data_addr_i = 32'd0; bus.in_delayslot_i = 1'b0;
        bus.cp0_status_i = 32'd0; bus.cp0_cause_i = 32'd0; bus.cp0_epc_i = 32'd0;
        bus.wb_cp0_we_i = 1'b0; bus.wb_cp0_waddr_i = 5'd0; bus.wb_cp0_wdata_i = 32'd0;
    endtask

    initial begin
        // flags: {eret,ades,adel_d,brk,sys,trap,ov,ri}
        vecs[0]  = '{8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1000, 32'h0, 32'h0C, 32'h0, 32'hBFC0_0380};
        vecs[1]  = '{8'h49, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1004, 32'h8000_2000, 32'h0A, 32'h0, 32'hBFC0_0380};
        vecs[2]  = '{8'h40, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1008, 32'h8000_2003, 32'h05, 32'h8000_2003, 32'hBFC0_0380};
        vecs[3]  = '{8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_3001, 32'h8000_2000, 32'h04, 32'h8000_3001, 32'hBFC0_0380};
        vecs[4]  = '{8'h0C, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1010, 32'h0, 32'h0D, 32'h0, 32'hBFC0_0380};
        vecs[5]  = '{8'h18, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1014, 32'h0, 32'h08, 32'h0, 32'hBFC0_0380};
        vecs[6]  = '{8'h10, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1018, 32'h0, 32'h09, 32'h0, 32'hBFC0_0380};
        vecs[7]  = '{8'h60, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_101C, 32'h8000_4001, 32'h04, 32'h8000_4001, 32'hBFC0_0380};
        vecs[8]  = '{8'h80, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8000_0100, 32'h8000_1020, 32'h0, 32'h0E, 32'h0, 32'h8000_0100};
        vecs[9]  = '{8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_1024, 32'h0, 32'h00, 32'h0, 32'h0};
        vecs[10] = '{8'h02, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h8000_1028, 32'h0, 32'h00, 32'h0, 32'h0};
        vecs[11] = '{8'h02, 1'b0, 1'b1, 1'b0, 32'h0000_FF01, 32'h0000_0400, 32'h0, 32'h8000_102C, 32'h0, 32'h01, 32'h0, 32'hBFC0_0380};
        vecs[12] = '{8'h02, 1'b0, 1'b1, 1'b0, 32'h0000_FF03, 32'h0000_0400, 32'h0, 32'h8000_1030, 32'h0, 32'h0C, 32'h0, 32'hBFC0_0380};
        vecs[13] = '{8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_FF03, 32'h0000_0400, 32'h0, 32'h8000_1034, 32'h0, 32'h00, 32'h0, 32'h0};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_FF00, 32'h0000_0400, 32'h0, 32'h8000_1038, 32'h0, 32'h00, 32'h0, 32'h0};

        clear_bus();
        bus3.int_i = 6'd0; bus3.timer_int_i = 1'b0; bus3.mem_valid_i = 1'b0;
        bus3.mem_stall_i = 1'b0; bus3.exc_flags_i = 8'd0; bus3.adel_f_i = 1'b0;
        bus3.pc_i = 32'h8000_5000; bus3.data_addr_i = 32'd0; bus3.in_delayslot_i = 1'b0;
        bus3.cp0_status_i = 32'd0; bus3.cp0_cause_i = 32'd0; bus3.cp0_epc_i = 32'd0;
        bus3.wb_cp0_we_i = 1'b0; bus3.wb_cp0_waddr_i = 5'd0; bus3.wb_cp0_wdata_i = 32'd0;

        repeat (2) tick();
        rst = 1'b1; rst3 = 1'b1;
        tick();
        chk("reset_flush", {31'd0, bus.flush_o}, 32'd0);
        chk("reset_code", bus.excepttype_o, 32'd0);
        chk("reset_int_sync", {26'd0, bus.int_sync_o}, 32'd0);
        chk("reset_new_pc", bus.new_pc_o, 32'd0);

        // Table-driven priority / commit vectors
        for (int i = 0; i < 15; i++) begin
            bus.exc_flags_i = vecs[i].flags;  bus.adel_f_i = vecs[i].adel_f;
            bus.mem_valid_i = vecs[i].valid;  bus.mem_stall_i = vecs[i].stall;
            bus.cp0_status_i = vecs[i].st;    bus.cp0_cause_i = vecs[i].ca;
            bus.cp0_epc_i = vecs[i].epc;      bus.pc_i = vecs[i].pc;
            bus.data_addr_i = vecs[i].daddr;  bus.in_delayslot_i = i[0];
            #2;
            chk($sformatf("v%0d_code", i), bus.excepttype_o, vecs[i].exp_code);
            chk($sformatf("v%0d_bad", i), bus.bad_addr_o, vecs[i].exp_bad);
            chk($sformatf("v%0d_epc", i), bus.exc_pc_o, vecs[i].pc);
            chk($sformatf("v%0d_ds", i), {31'd0, bus.exc_delayslot_o}, {31'd0, i[0]});
            tick();
            chk($sformatf("v%0d_flush", i), {31'd0, bus.flush_o},
                {31'd0, (vecs[i].exp_code != 32'd0)});
            if (vecs[i].exp_code != 32'd0) begin
                chk($sformatf("v%0d_new_pc", i), bus.new_pc_o, vecs[i].exp_npc);
            end
            bus.mem_valid_i = 1'b0; bus.exc_flags_i = 8'd0; bus.adel_f_i = 1'b0;
            tick();
            chk($sformatf("v%0d_flush_end", i), {31'd0, bus.flush_o}, 32'd0);
        end
        clear_bus();

        // Interrupt synchroniser latency, interrupt commit and EXL masking
        bus.cp0_status_i = 32'h0000_FF01;
        bus.int_i = 6'b000100;
        tick();
        chk("sync_edge1", {26'd0, bus.int_sync_o}, 32'd0);
        tick();
        chk("sync_edge2", {26'd0, bus.int_sync_o}, 32'h0000_0004);
        bus.cp0_cause_i = 32'h0000_1000;
        bus.mem_valid_i = 1'b1;
        #2;
        chk("int_code", bus.excepttype_o, 32'h01);
        tick();
        chk("int_flush", {31'd0, bus.flush_o}, 32'd1);
        chk("int_new_pc", bus.new_pc_o, 32'hBFC0_0380);
        bus.mem_valid_i = 1'b0;
        tick();
        bus.cp0_status_i = 32'h0000_FF03;
        bus.mem_valid_i = 1'b1;
        #2;
        chk("exl_code", bus.excepttype_o, 32'h00);
        tick();
        chk("exl_flush", {31'd0, bus.flush_o}, 32'd0);
        bus.timer_int_i = 1'b1;
        #1;
        chk("timer_sync", {26'd0, bus.int_sync_o}, 32'h0000_0024);
        clear_bus();
        tick();

        // ERET with EPC forwarded from WB
        bus.exc_flags_i = 8'h80; bus.mem_valid_i = 1'b1;
        bus.cp0_epc_i = 32'h8000_0100;
        bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd14; bus.wb_cp0_wdata_i = 32'h8000_0200;
        #2;
        chk("eret_code", bus.excepttype_o, 32'h0E);
        tick();
        chk("eret_new_pc", bus.new_pc_o, 32'h8000_0200);
        clear_bus();
        tick();

        // STATUS forwarding enables an interrupt
        bus.mem_valid_i = 1'b1; bus.cp0_cause_i = 32'h0000_0400;
        bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd12; bus.wb_cp0_wdata_i = 32'h0000_FF01;
        #2;
        chk("fwd_status_code", bus.excepttype_o, 32'h01);
        bus.mem_valid_i = 1'b0;
        tick();
        clear_bus();
        tick();

        // CAUSE forwarding touches IP1..IP0 only
        bus.mem_valid_i = 1'b1; bus.cp0_status_i = 32'h0000_0301;
        bus.wb_cp0_we_i = 1'b1; bus.wb_cp0_waddr_i = 5'd13; bus.wb_cp0_wdata_i = 32'h0000_0300;
        #2;
        chk("fwd_cause_sw", bus.excepttype_o, 32'h01);
        bus.cp0_status_i = 32'h0000_FC01; bus.wb_cp0_wdata_i = 32'h0000_FC00;
        #1;
        chk("fwd_cause_hw_ignored", bus.excepttype_o, 32'h00);
        bus.mem_valid_i = 1'b0;
        tick();
        clear_bus();
        tick();

        // Stall defers the commit
        bus.exc_flags_i = 8'h02; bus.mem_valid_i = 1'b1; bus.mem_stall_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            chk($sformatf("stall%0d_code", c), bus.excepttype_o, 32'h00);
            tick();
            chk($sformatf("stall%0d_flush", c), {31'd0, bus.flush_o}, 32'd0);
        end
        bus.mem_stall_i = 1'b0;
        #2;
        chk("unstall_code", bus.excepttype_o, 32'h0C);
        tick();
        chk("unstall_flush", {31'd0, bus.flush_o}, 32'd1);

        // Back-to-back: inputs held through FLUSH, recommit in next IDLE cycle
        chk("b2b_code_in_flush", bus.excepttype_o, 32'h00);
        tick();
        chk("b2b_flush_gap", {31'd0, bus.flush_o}, 32'd0);
        chk("b2b_code_recommit", bus.excepttype_o, 32'h0C);
        tick();
        chk("b2b_flush_again", {31'd0, bus.flush_o}, 32'd1);
        clear_bus();
        tick();

        // FLUSH_CYCLES=3: three flush cycles, then reset mid-flush
        bus3.exc_flags_i = 8'h02; bus3.mem_valid_i = 1'b1;
        #2;
        chk("f3_code", bus3.excepttype_o, 32'h0C);
        tick();
        bus3.mem_valid_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("f3_flush_T%0d", c), {31'd0, bus3.flush_o}, {31'd0, (c <= 3)});
            tick();
        end
        bus3.mem_valid_i = 1'b1;
        tick();
        bus3.mem_valid_i = 1'b0;
        tick();
        chk("f3_flush_cycle2", {31'd0, bus3.flush_o}, 32'd1);
        #2;
        rst3 = 1'b0;
        #1;
        chk("f3_rst_flush", {31'd0, bus3.flush_o}, 32'd0);
        tick();
        rst3 = 1'b1;
        tick();
        chk("f3_after_rst_flush", {31'd0, bus3.flush_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
